// File: rtl/wb_rr_arbiter.sv
// Wishbone B4 classic-cycle arbiter: NUM_MASTERS masters share one slave port
// under round-robin priority, with LOCK support and a slave-hang timeout.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TAG_W       = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_cyc_o,
  input  logic [NUM_MASTERS-1:0]          m_stb_o,
  input  logic [NUM_MASTERS-1:0]          m_we_o,
  input  logic [NUM_MASTERS-1:0]          m_lock_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_o,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_o,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_o,
  input  logic [NUM_MASTERS*TAG_W-1:0]    m_tga_o,
  input  logic [NUM_MASTERS*TAG_W-1:0]    m_tgc_o,
  output logic [NUM_MASTERS-1:0]          m_ack_i,
  output logic [NUM_MASTERS-1:0]          m_err_i,
  output logic [NUM_MASTERS-1:0]          m_rty_i,
  output logic [DATA_W-1:0]               m_dat_i,
  output logic [TAG_W-1:0]                m_tgd_i,
  output logic                            s_cyc_i,
  output logic                            s_stb_i,
  output logic                            s_we_i,
  output logic                            s_lock_i,
  output logic [ADDR_W-1:0]               s_adr_i,
  output logic [DATA_W-1:0]               s_dat_i,
  output logic [DATA_W/8-1:0]             s_sel_i,
  output logic [TAG_W-1:0]                s_tga_i,
  output logic [TAG_W-1:0]                s_tgc_i,
  input  logic [DATA_W-1:0]               s_dat_o,
  input  logic [TAG_W-1:0]                s_tgd_o,
  input  logic                            s_ack_o,
  input  logic                            s_err_o,
  input  logic                            s_rty_o,
  output logic [NUM_MASTERS-1:0]          gnt
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [15:0]      TMO_LIMIT = 16'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   found;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       pick;
  logic                   owned;
  logic                   tmo;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    pick  = ptr_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_MASTERS);
      if (!found && m_cyc_o[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = OWNED;
          idx_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end
      OWNED: begin
        // A locked master keeps the bus even between its CYC bursts.
        if (!m_cyc_o[idx_q] && !m_lock_o[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign owned = (state_q == OWNED);
  assign tmo   = owned && (cnt_q == TMO_LIMIT);

  always_comb begin
    s_cyc_i  = 1'b0;
    s_stb_i  = 1'b0;
    s_we_i   = 1'b0;
    s_lock_i = 1'b0;
    s_adr_i  = '0;
    s_dat_i  = '0;
    s_sel_i  = '0;
    s_tga_i  = '0;
    s_tgc_i  = '0;
    if (owned) begin
      s_cyc_i  = m_cyc_o[idx_q];
      s_stb_i  = m_stb_o[idx_q] && !tmo;
      s_we_i   = m_we_o[idx_q];
      s_lock_i = m_lock_o[idx_q];
      s_adr_i  = m_adr_o[idx_q*ADDR_W +: ADDR_W];
      s_dat_i  = m_dat_o[idx_q*DATA_W +: DATA_W];
      s_sel_i  = m_sel_o[idx_q*SEL_W +: SEL_W];
      s_tga_i  = m_tga_o[idx_q*TAG_W +: TAG_W];
      s_tgc_i  = m_tgc_o[idx_q*TAG_W +: TAG_W];
    end
  end

  always_comb begin
    if (tmo || !s_stb_i || s_ack_o || s_err_o || s_rty_o)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;
  end

  // gnt_q is all-zero when idle, so it doubles as the termination route mask.
  assign m_ack_i = gnt_q & {NUM_MASTERS{s_ack_o}};
  assign m_err_i = gnt_q & {NUM_MASTERS{s_err_o | tmo}};
  assign m_rty_i = gnt_q & {NUM_MASTERS{s_rty_o}};
  assign m_dat_i = s_dat_o;
  assign m_tgd_i = s_tgd_o;
  assign gnt     = gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
